// File: rtl/rc4.sv
// RC4 keystream generator: S-box init, key scheduling and PRGA over a 256x8
// register-file S-box with one async read port, one write port and one read/write port.
module rc4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] key,
    input  logic [7:0]  key_length,
    output logic [2:0]  state,
    output logic        wen,
    output logic [7:0]  i_out,
    output logic [7:0]  j_out,
    output logic [7:0]  k_out,
    output logic [7:0]  raddr_1,
    output logic [7:0]  rdata_1,
    output logic [7:0]  waddr_2,
    output logic [7:0]  wdata_2,
    output logic [7:0]  addr_3,
    output logic [7:0]  rdata_3,
    output logic [7:0]  wdata_3,
    output logic [7:0]  ckey,
    output logic        done
);

    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned KIDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_KSA1 = 3'd2,
        ST_KSA2 = 3'd3,
        ST_PRG1 = 3'd4,
        ST_PRG2 = 3'd5,
        ST_PRG3 = 3'd6
    } state_t;

    state_t              r_state;
    logic [KEY_W-1:0]    r_key;
    logic [KIDX_W-1:0]   r_len_m1;
    logic [KIDX_W-1:0]   r_kidx;
    logic [DW-1:0]       r_i;
    logic [DW-1:0]       r_j;
    logic [DW-1:0]       r_k;
    logic [DW-1:0]       r_si;
    logic [DW-1:0]       r_ckey;
    logic                r_done;
    logic [DW-1:0]       r_sbox [DEPTH];

    state_t              w_state_nxt;
    logic [KEY_W-1:0]    w_key_nxt;
    logic [KIDX_W-1:0]   w_len_m1_nxt;
    logic [KIDX_W-1:0]   w_kidx_nxt;
    logic [DW-1:0]       w_i_nxt;
    logic [DW-1:0]       w_j_nxt;
    logic [DW-1:0]       w_k_nxt;
    logic [DW-1:0]       w_si_nxt;
    logic [DW-1:0]       w_ckey_nxt;
    logic                w_done_nxt;

    logic [DW-1:0]       w_raddr_1;
    logic [DW-1:0]       w_rdata_1;
    logic [DW-1:0]       w_addr_3;
    logic [DW-1:0]       w_rdata_3;
    logic [DW-1:0]       w_waddr_2;
    logic [DW-1:0]       w_wdata_2;
    logic [DW-1:0]       w_wdata_3;
    logic                w_wen;
    logic [DW-1:0]       w_jn;
    logic [DW-1:0]       w_keybyte;
    logic [KIDX_W-1:0]   w_len_m1_in;
    logic                w_rd1_used;
    logic                w_rd3_used;

    // Read addresses are split from the write datapath so port 3's address can depend on port 1's data
    always_comb begin
        w_raddr_1 = '0;
        case (r_state)
            ST_KSA1, ST_PRG2: w_raddr_1 = r_i;
            ST_PRG3:          w_raddr_1 = r_k;
            default:          w_raddr_1 = '0;
        endcase
    end

    assign w_rdata_1 = r_sbox[w_raddr_1];
    assign w_jn      = r_j + w_rdata_1;

    always_comb begin
        w_addr_3 = '0;
        case (r_state)
            ST_INIT: w_addr_3 = r_i;
            ST_KSA2: w_addr_3 = r_j;
            ST_PRG2: w_addr_3 = w_jn;
            default: w_addr_3 = '0;
        endcase
    end

    assign w_rdata_3 = r_sbox[w_addr_3];
    assign w_keybyte = r_key[{r_kidx, 3'b000} +: DW];

    // Lengths of 0 or above 4 select the full 4-byte key
    assign w_len_m1_in = ((key_length == 8'd0) || (key_length > 8'd4))
                         ? KIDX_W'(3) : KIDX_W'(key_length - 8'd1);

    // Next-state and write-port control
    always_comb begin
        w_state_nxt  = r_state;
        w_key_nxt    = r_key;
        w_len_m1_nxt = r_len_m1;
        w_kidx_nxt   = r_kidx;
        w_i_nxt      = r_i;
        w_j_nxt      = r_j;
        w_k_nxt      = r_k;
        w_si_nxt     = r_si;
        w_ckey_nxt   = r_ckey;
        w_done_nxt   = 1'b0;
        w_wen        = 1'b0;
        w_waddr_2    = '0;
        w_wdata_2    = '0;
        w_wdata_3    = '0;
        w_rd1_used   = 1'b0;
        w_rd3_used   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_key_nxt    = key;
                    w_len_m1_nxt = w_len_m1_in;
                    w_kidx_nxt   = '0;
                    w_i_nxt      = '0;
                    w_j_nxt      = '0;
                    w_state_nxt  = ST_INIT;
                end
            end
            ST_INIT: begin
                w_wen     = 1'b1;
                w_waddr_2 = r_i;
                w_wdata_2 = r_i;
                w_wdata_3 = r_i;
                w_i_nxt   = r_i + DW'(1);
                if (r_i == DW'(DEPTH - 1)) begin
                    w_state_nxt = ST_KSA1;
                end
            end
            ST_KSA1: begin
                w_rd1_used  = 1'b1;
                w_j_nxt     = r_j + w_rdata_1 + w_keybyte;
                w_si_nxt    = w_rdata_1;
                w_state_nxt = ST_KSA2;
            end
            ST_KSA2: begin
                w_rd3_used = 1'b1;
                w_wen      = 1'b1;
                w_waddr_2  = r_i;
                w_wdata_2  = w_rdata_3;
                w_wdata_3  = r_si;
                w_i_nxt    = r_i + DW'(1);
                w_kidx_nxt = (r_kidx == r_len_m1) ? '0 : r_kidx + KIDX_W'(1);
                if (r_i == DW'(DEPTH - 1)) begin
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_state_nxt = ST_PRG1;
                end else begin
                    w_state_nxt = ST_KSA1;
                end
            end
            ST_PRG1: begin
                w_i_nxt     = r_i + DW'(1);
                w_state_nxt = ST_PRG2;
            end
            ST_PRG2: begin
                w_rd1_used  = 1'b1;
                w_rd3_used  = 1'b1;
                w_wen       = 1'b1;
                w_waddr_2   = r_i;
                w_wdata_2   = w_rdata_3;
                w_wdata_3   = w_rdata_1;
                w_j_nxt     = w_jn;
                w_k_nxt     = w_rdata_1 + w_rdata_3;
                w_state_nxt = ST_PRG3;
            end
            ST_PRG3: begin
                w_rd1_used  = 1'b1;
                w_ckey_nxt  = w_rdata_1;
                w_done_nxt  = 1'b1;
                w_state_nxt = start ? ST_PRG1 : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_key    <= '0;
            r_len_m1 <= '0;
            r_kidx   <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_si     <= '0;
            r_ckey   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_key    <= w_key_nxt;
            r_len_m1 <= w_len_m1_nxt;
            r_kidx   <= w_kidx_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_si     <= w_si_nxt;
            r_ckey   <= w_ckey_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // S-box is not reset; port 3 is written last so it wins on i == j
    always_ff @(posedge clk) begin
        if (w_wen) begin
            r_sbox[w_waddr_2] <= w_wdata_2;
            r_sbox[w_addr_3]  <= w_wdata_3;
        end
    end

    assign state   = 3'(r_state);
    assign wen     = w_wen;
    assign i_out   = r_i;
    assign j_out   = r_j;
    assign k_out   = r_k;
    assign raddr_1 = w_raddr_1;
    assign rdata_1 = w_rd1_used ? w_rdata_1 : '0;
    assign waddr_2 = w_waddr_2;
    assign wdata_2 = w_wdata_2;
    assign addr_3  = w_addr_3;
    assign rdata_3 = w_rd3_used ? w_rdata_3 : '0;
    assign wdata_3 = w_wdata_3;
    assign ckey    = r_ckey;
    assign done    = r_done;

endmodule

// File: tb/tb_rc4.sv
// Directed bench for rc4: known RC4 keystreams, start-to-first-byte latency,
// INIT write sequence, start drop and mid-KSA reset recovery.
module tb_rc4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] key;
    logic [7:0]  key_length;
    logic [2:0]  state;
    logic        wen;
    logic [7:0]  i_out, j_out, k_out;
    logic [7:0]  raddr_1, rdata_1, waddr_2, wdata_2;
    logic [7:0]  addr_3, rdata_3, wdata_3;
    logic [7:0]  ckey;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_key  [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                                  8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    logic [7:0] exp_wiki [10] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41,
                                  8'hB7, 8'h00, 8'h00, 8'h00, 8'h00};

    rc4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .key_length (key_length),
        .state      (state),
        .wen        (wen),
        .i_out      (i_out),
        .j_out      (j_out),
        .k_out      (k_out),
        .raddr_1    (raddr_1),
        .rdata_1    (rdata_1),
        .waddr_2    (waddr_2),
        .wdata_2    (wdata_2),
        .addr_3     (addr_3),
        .rdata_3    (rdata_3),
        .wdata_3    (wdata_3),
        .ckey       (ckey),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycles are counted in negedges after the call; timeout is a failed check
    task automatic wait_done(input int budget, output logic [7:0] b, output int cyc, output bit ok);
        ok  = 1'b0;
        b   = '0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                b  = ckey;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((state != 3'd0) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'd0);
    endtask

    task automatic run_stream(input string tag, input logic [31:0] k, input logic [7:0] len,
                              input logic [7:0] exp [10], input int nbytes);
        logic [7:0] b;
        int         cyc;
        bit         ok;
        @(negedge clk);
        key        = k;
        key_length = len;
        start      = 1'b1;
        for (int n = 0; n < nbytes; n++) begin
            wait_done(1000, b, cyc, ok);
            if (!ok) break;
            check($sformatf("%s_byte%0d", tag, n), 32'(b), 32'(exp[n]));
        end
        start = 1'b0;
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        logic [31:0] acc;
        logic [7:0]  b;
        int          cyc;
        int          n;
        int          init_err;
        bit          ok;

        rst_n      = 1'b0;
        start      = 1'b0;
        key        = '0;
        key_length = '0;

        // Reset state, and quiet outputs with start low
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        acc   = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc |= 32'(state) | 32'(wen) | 32'(i_out) | 32'(j_out) | 32'(k_out)
                 | 32'(raddr_1) | 32'(rdata_1) | 32'(waddr_2) | 32'(wdata_2)
                 | 32'(addr_3) | 32'(rdata_3) | 32'(wdata_3) | 32'(ckey) | 32'(done);
        end
        check("rst_quiet", acc, 32'd0);

        run_stream("key3", 32'h0079654B, 8'd3, exp_key, 10);
        run_stream("wiki4", 32'h696B6957, 8'd4, exp_wiki, 6);

        // Latency and INIT write sequence
        @(negedge clk);
        key        = 32'h64636261;
        key_length = 8'd4;
        start      = 1'b1;
        n          = 0;
        init_err   = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (n <= 256) begin
                if (!(state == 3'd1 && wen && waddr_2 == 8'(n - 1) && wdata_2 == 8'(n - 1)
                      && addr_3 == 8'(n - 1) && wdata_3 == 8'(n - 1)))
                    init_err++;
            end
            if (done) break;
        end
        check("init_seq", 32'(init_err), 32'd0);
        check("first_done_edges", 32'(n - 1), 32'd771);
        for (int m = 0; m < 3; m++) begin
            wait_done(10, b, cyc, ok);
            check($sformatf("byte_gap%0d", m), 32'(cyc), 32'd3);
        end
        start = 1'b0;
        wait_idle("abcd_idle");

        run_stream("wiki_len0", 32'h696B6957, 8'd0, exp_wiki, 6);

        // Drop start after the second byte: one more byte, then IDLE
        @(negedge clk);
        key        = 32'h0079654B;
        key_length = 8'd3;
        start      = 1'b1;
        for (int m = 0; m < 2; m++) begin
            wait_done(1000, b, cyc, ok);
            check($sformatf("drop_byte%0d", m), 32'(b), 32'(exp_key[m]));
        end
        start = 1'b0;
        wait_done(10, b, cyc, ok);
        check("drop_last_byte", 32'(b), 32'(exp_key[2]));
        check("drop_last_gap", 32'(cyc), 32'd3);
        check("drop_state", 32'(state), 32'd0);
        acc = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc |= 32'(done) | 32'(state) | 32'(wen);
        end
        check("drop_quiet", acc, 32'd0);
        check("drop_ckey_hold", 32'(ckey), 32'(exp_key[2]));

        // Reset during KSA, then restart with start still high
        @(negedge clk);
        start = 1'b1;
        repeat (400) @(negedge clk);
        check("mid_ksa", 32'(state == 3'd2 || state == 3'd3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_ij", {16'h0, i_out, j_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 4; m++) begin
            wait_done(1000, b, cyc, ok);
            if (!ok) break;
            check($sformatf("restart_byte%0d", m), 32'(b), 32'(exp_key[m]));
        end
        start = 1'b0;
        wait_idle("restart_idle");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rc4.md
# rc4

RC4 keystream generator with an internal 256×8 S-box memory. On `start` it latches a key of up to 4 bytes, runs state initialisation (S[i]=i), the key-scheduling algorithm (KSA) and then the pseudo-random generation algorithm (PRGA). The PRGA emits one keystream byte on `ckey` every 3 cycles for as long as `start` stays high. It sits between a host that supplies the key and a downstream XOR stage. Memory port signals and internal counters are exported for observation.

## Interface
- No parameters.
- Clocking/reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: level request; sampled in IDLE; keeps PRGA running while high.
- `key` in 32: key bytes, little-endian; byte n = key[8n+7:8n].
- `key_length` in 8: key length in bytes, 1..4; 0 or >4 treated as 4.
- `state` out 3: FSM state code.
- `wen` out 1: S-box write enable for this cycle.
- `i_out`, `j_out`, `k_out` out 8 each: RC4 index registers i, j, k.
- `raddr_1` out 8, `rdata_1` out 8: port 1 (read-only, asynchronous read).
- `waddr_2` out 8, `wdata_2` out 8: port 2 (write-only, synchronous, gated by `wen`).
- `addr_3` out 8, `rdata_3` out 8, `wdata_3` out 8: port 3 (async read, sync write gated by `wen`).
- `ckey` out 8: latest keystream byte.
- `done` out 1: one-cycle pulse, high in the cycle a new `ckey` byte is first visible.

## Operation
- States: IDLE=0, INIT=1, KSA1=2, KSA2=3, PRG1=4, PRG2=5, PRG3=6; code 7 is unused and recovers to IDLE.
- IDLE: if `start`=1, latch `key` and `key_length`, clear i and j, go to INIT.
- INIT: `wen`=1, `waddr_2`=`addr_3`=i, `wdata_2`=`wdata_3`=i; i++. After i=255, i wraps to 0 and the FSM goes to KSA1.
- KSA1: `raddr_1`=i; j <= j + `rdata_1` + keybyte[i mod len]; go to KSA2.
- KSA2: `addr_3`=j, `waddr_2`=i, `wdata_2`=`rdata_3`, `wdata_3`=S[i] (held from KSA1), `wen`=1.
  - Swap completes at the edge; i++.
  - After i=255, clear i and j and go to PRG1; otherwise go to KSA1.
- PRG1: i <= i+1.
- PRG2: `raddr_1`=i, jn = j + `rdata_1`, `addr_3`=jn, j <= jn; swap as in KSA2 (`wen`=1); k <= `rdata_1` + `rdata_3` (pre-swap values).
- PRG3: `raddr_1`=k; `ckey` <= `rdata_1`, `done` <= 1. Next state is PRG1 if `start`=1, otherwise IDLE.
- Arithmetic is modulo 256 (8-bit wrap). `key_length` 3 with i mod 3 uses a counter, not a divider.
- Same-address write on ports 2 and 3 (i==j): both carry the same value; port 3 wins.
- Address/data outputs not used in a state are driven to 0; `wen`=0 outside INIT, KSA2 and PRG2.
- `start` dropping during INIT/KSA is ignored; the sequence completes, then the first PRG3 returns to IDLE.
- S-box contents are not reset (INIT rewrites them).

## Timing
- Reset: `state`=IDLE, i/j/k=0, `ckey`=0, `done`=0, `wen`=0; all addresses and write data 0.
- Reset mid-operation aborts immediately; a new `start` restarts from INIT.
- Latency, counted from the edge that samples `start` in IDLE:
  - INIT: 256 cycles.
  - KSA: 512 cycles.
  - First `ckey`/`done` visible after edge 256+512+3 = 771.
  - Subsequent bytes every 3 cycles.
- `done` is registered and high for exactly one cycle per byte.
- `ckey` holds its value until the next byte.

## Test plan
- Reset with `start`=0 -> all outputs 0, `state`=0, no `wen`, indefinitely.
- `key`=32'h0079654B ("Key"), `key_length`=3, `start` held 1 -> successive `ckey` at `done` pulses EB 9F 77 81 B7 34 CA 72 A7 19.
- `key`=32'h696B6957 ("Wiki"), `key_length`=4 -> `ckey` 60 44 DB 6D 41 B7.
- `key`=32'h64636261 ("abcd"), `key_length`=4 -> first `done` exactly 771 edges after the start-sampling edge, then every 3 cycles; INIT shows `waddr_2`=`wdata_2`=0..255 with `wen`=1.
- `key_length`=0 with "Wiki" key -> same stream as `key_length`=4.
- Drop `start` after the 2nd byte -> FSM returns to IDLE after the current PRG3. Assert `rst_n`=0 mid-KSA then restart -> stream identical to a clean run.
